// File: rtl/fetch_group_queue.sv
// N-wide fetch stage: owns the fetch PC, fetches ISSUE_W words per cycle into a circular
// queue and hands head groups to decode under deq_ready. Redirects flush the queue and
// steer the PC. Latency is 1 cycle. Fetch stalls when the queue has no room for a full group.
module fetch_group_queue #(
   parameter int unsigned ISSUE_W  = 2,
   parameter int unsigned FQ_DEPTH = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                            clk,
   input  logic                            reset,
   output logic [31:0]                     imem_addr,
   input  logic [32*ISSUE_W-1:0]           imem_rdata,
   input  logic [2*ISSUE_W-1:0]            pcsrc_d,
   input  logic [32*ISSUE_W-1:0]           pc_predict_d,
   input  logic [32*ISSUE_W-1:0]           pc_jump_d,
   input  logic                            deq_ready,
   output logic [ISSUE_W-1:0]              deq_valid,
   output logic [32*ISSUE_W-1:0]           instr_f,
   output logic [32*ISSUE_W-1:0]           pc_f,
   output logic [32*ISSUE_W-1:0]           pc_plus_w_f,
   output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
);

   localparam int unsigned PW = $clog2(FQ_DEPTH);
   localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
   localparam logic [CW-1:0] GROUP     = CW'(ISSUE_W);
   localparam logic [CW-1:0] PUSH_MAX  = CW'(FQ_DEPTH - ISSUE_W);
   localparam logic [31:0]   GROUP_INC = 32'(4 * ISSUE_W);

   logic [31:0]   pc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic [31:0] q_instr [FQ_DEPTH];
   logic [31:0] q_pc    [FQ_DEPTH];

   logic          redir;
   logic [31:0]   redir_target;
   logic          push;
   logic          pop;
   logic [CW-1:0] popped;

   // Oldest lane with a live redirect code wins; code 3 is ignored.
   always_comb begin
      redir        = 1'b0;
      redir_target = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         if (!redir && (pcsrc_d[2*i +: 2] == 2'd1 || pcsrc_d[2*i +: 2] == 2'd2)) begin
            redir        = 1'b1;
            redir_target = (pcsrc_d[2*i +: 2] == 2'd1) ? pc_predict_d[32*i +: 32]
                                                       : pc_jump_d[32*i +: 32];
         end
      end
      redir_target[1:0] = 2'b00;
   end

   // Push-space test uses the occupancy before this cycle's pop.
   assign push   = !redir && (count <= PUSH_MAX);
   assign pop    = !redir && deq_ready && (count != '0);
   assign popped = pop ? ((count < GROUP) ? count : GROUP) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redir) begin
         pc    <= redir_target;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            pc   <= pc + GROUP_INC;
            tail <= tail + PW'(ISSUE_W);
         end
         head  <= head + PW'(popped);
         count <= count + (push ? GROUP : '0) - popped;
      end
   end

   // Storage has no reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         for (int i = 0; i < ISSUE_W; i++) begin
            q_instr[tail + PW'(i)] <= imem_rdata[32*i +: 32];
            q_pc[tail + PW'(i)]    <= pc + 32'(4 * i);
         end
      end
   end

   always_comb begin
      deq_valid   = '0;
      instr_f     = '0;
      pc_f        = '0;
      pc_plus_w_f = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         if (count > CW'(i)) begin
            deq_valid[i]            = 1'b1;
            instr_f[32*i +: 32]     = q_instr[head + PW'(i)];
            pc_f[32*i +: 32]        = q_pc[head + PW'(i)];
            pc_plus_w_f[32*i +: 32] = q_pc[head + PW'(i)] + GROUP_INC;
         end
      end
   end

   assign imem_addr = pc;
   assign fq_count  = count;

endmodule

// File: tb/tb_fetch_group_queue.sv
// Bench for fetch_group_queue (ISSUE_W=2, FQ_DEPTH=8): fixed vector table, wrap sequence,
// then random traffic compared against a queue-based reference model.
module tb_fetch_group_queue;

   localparam int W     = 2;
   localparam int DEPTH = 8;

   logic              clk;
   logic              reset;
   logic [31:0]       imem_addr;
   logic [32*W-1:0]   imem_rdata;
   logic [2*W-1:0]    pcsrc_d;
   logic [32*W-1:0]   pc_predict_d;
   logic [32*W-1:0]   pc_jump_d;
   logic              deq_ready;
   logic [W-1:0]      deq_valid;
   logic [32*W-1:0]   instr_f;
   logic [32*W-1:0]   pc_f;
   logic [32*W-1:0]   pc_plus_w_f;
   logic [3:0]        fq_count;

   fetch_group_queue #(.ISSUE_W(W), .FQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .pcsrc_d      (pcsrc_d),
      .pc_predict_d (pc_predict_d),
      .pc_jump_d    (pc_jump_d),
      .deq_ready    (deq_ready),
      .deq_valid    (deq_valid),
      .instr_f      (instr_f),
      .pc_f         (pc_f),
      .pc_plus_w_f  (pc_plus_w_f),
      .fq_count     (fq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < W; i++)
         imem_rdata[32*i +: 32] = 32'hA000_0000 | (imem_addr + 32'(4 * i));
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: the queue contents as plain lists of fetched words and their PCs.
   logic [31:0] mq_ins[$];
   logic [31:0] mq_pc[$];
   logic [31:0] m_pc = 32'h0;

   task automatic model_step(input logic rst, input logic [2*W-1:0] src,
                             input logic [32*W-1:0] pred, input logic [32*W-1:0] jmp,
                             input logic rdy);
      int win;
      int npop;
      bit space;
      logic [31:0] tgt;
      if (rst) begin
         mq_ins.delete();
         mq_pc.delete();
         m_pc = 32'h0;
      end else begin
         win = -1;
         for (int i = 0; i < W; i++)
            if (win < 0 && (src[2*i +: 2] == 2'd1 || src[2*i +: 2] == 2'd2)) win = i;
         if (win >= 0) begin
            tgt  = (src[2*win +: 2] == 2'd1) ? pred[32*win +: 32] : jmp[32*win +: 32];
            m_pc = tgt & ~32'h3;
            mq_ins.delete();
            mq_pc.delete();
         end else begin
            space = (mq_pc.size() <= DEPTH - W);
            npop  = rdy ? ((mq_pc.size() < W) ? mq_pc.size() : W) : 0;
            repeat (npop) begin
               void'(mq_ins.pop_front());
               void'(mq_pc.pop_front());
            end
            if (space) begin
               for (int i = 0; i < W; i++) begin
                  mq_pc.push_back(m_pc + 32'(4 * i));
                  mq_ins.push_back(32'hA000_0000 | (m_pc + 32'(4 * i)));
               end
               m_pc = m_pc + 32'(4 * W);
            end
         end
      end
   endtask

   task automatic model_check();
      logic v;
      chk("model_fq_count", 64'(fq_count), 64'(mq_pc.size()));
      chk("model_imem_addr", 64'(imem_addr), 64'(m_pc));
      for (int i = 0; i < W; i++) begin
         v = (i < mq_pc.size());
         chk($sformatf("model_valid%0d", i), 64'(deq_valid[i]), 64'(v));
         chk($sformatf("model_instr%0d", i), 64'(instr_f[32*i +: 32]), v ? 64'(mq_ins[i]) : 64'h0);
         chk($sformatf("model_pc%0d", i), 64'(pc_f[32*i +: 32]), v ? 64'(mq_pc[i]) : 64'h0);
         chk($sformatf("model_pcw%0d", i), 64'(pc_plus_w_f[32*i +: 32]),
             v ? 64'(mq_pc[i] + 32'(4 * W)) : 64'h0);
      end
   endtask

   // Drive one cycle's inputs, advance the model, and check the outputs after the edge.
   task automatic cycle(input logic rst, input logic [2*W-1:0] src, input logic [32*W-1:0] pred,
                        input logic [32*W-1:0] jmp, input logic rdy);
      reset        = rst;
      pcsrc_d      = src;
      pc_predict_d = pred;
      pc_jump_d    = jmp;
      deq_ready    = rdy;
      model_step(rst, src, pred, jmp, rdy);
      @(posedge clk);
      #1;
      model_check();
   endtask

   typedef struct {
      logic         rst;
      logic [3:0]   src;
      logic [63:0]  pred;
      logic [63:0]  jmp;
      logic         rdy;
      logic [3:0]   e_cnt;
      logic [31:0]  e_addr;
      logic [1:0]   e_vld;
      logic [31:0]  e_pc0;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [3:0] src, input logic [63:0] pred,
                               input logic [63:0] jmp, input logic rdy, input logic [3:0] cnt,
                               input logic [31:0] addr, input logic [1:0] vld, input logic [31:0] pc0);
      vec_t v;
      v.rst = rst; v.src = src; v.pred = pred; v.jmp = jmp; v.rdy = rdy;
      v.e_cnt = cnt; v.e_addr = addr; v.e_vld = vld; v.e_pc0 = pc0;
      return v;
   endfunction

   vec_t tbl[25];

   initial begin
      logic [31:0] e_ins0;
      logic        rst_r;
      logic [3:0]  src_r;
      logic [63:0] pred_r;
      logic [63:0] jmp_r;

      // fill to full, then drain one group while full
      tbl[0]  = mk(1, 4'b0000, 64'h0, 64'h0, 0, 0, 32'h00, 2'b00, 32'h00);
      tbl[1]  = mk(0, 4'b0000, 64'h0, 64'h0, 0, 2, 32'h08, 2'b11, 32'h00);
      tbl[2]  = mk(0, 4'b0000, 64'h0, 64'h0, 0, 4, 32'h10, 2'b11, 32'h00);
      tbl[3]  = mk(0, 4'b0000, 64'h0, 64'h0, 0, 6, 32'h18, 2'b11, 32'h00);
      tbl[4]  = mk(0, 4'b0000, 64'h0, 64'h0, 0, 8, 32'h20, 2'b11, 32'h00);
      tbl[5]  = mk(0, 4'b0000, 64'h0, 64'h0, 0, 8, 32'h20, 2'b11, 32'h00);
      tbl[6]  = mk(0, 4'b0000, 64'h0, 64'h0, 1, 6, 32'h20, 2'b11, 32'h08);
      // streaming
      tbl[7]  = mk(1, 4'b0000, 64'h0, 64'h0, 0, 0, 32'h00, 2'b00, 32'h00);
      tbl[8]  = mk(0, 4'b0000, 64'h0, 64'h0, 1, 2, 32'h08, 2'b11, 32'h00);
      tbl[9]  = mk(0, 4'b0000, 64'h0, 64'h0, 1, 2, 32'h10, 2'b11, 32'h08);
      tbl[10] = mk(0, 4'b0000, 64'h0, 64'h0, 1, 2, 32'h18, 2'b11, 32'h10);
      // jump on lane 1, then target group after one bubble
      tbl[11] = mk(0, 4'b1000, 64'h0, {32'h43, 32'h0}, 1, 0, 32'h40, 2'b00, 32'h00);
      tbl[12] = mk(0, 4'b0000, 64'h0, 64'h0, 0, 2, 32'h48, 2'b11, 32'h40);
      // both lanes redirect: lane 0 wins; code 3 does not flush
      tbl[13] = mk(0, 4'b1001, {32'h0, 32'h100}, {32'h200, 32'h0}, 1, 0, 32'h100, 2'b00, 32'h00);
      tbl[14] = mk(0, 4'b1111, 64'h0, 64'h0, 0, 2, 32'h108, 2'b11, 32'h100);
      tbl[15] = mk(0, 4'b1111, 64'h0, 64'h0, 0, 4, 32'h110, 2'b11, 32'h100);
      // build fq_count=6 with pc=0x30, then reset with a concurrent redirect
      tbl[16] = mk(1, 4'b0000, 64'h0, 64'h0, 0, 0, 32'h00, 2'b00, 32'h00);
      tbl[17] = mk(0, 4'b0000, 64'h0, 64'h0, 1, 2, 32'h08, 2'b11, 32'h00);
      tbl[18] = mk(0, 4'b0000, 64'h0, 64'h0, 1, 2, 32'h10, 2'b11, 32'h08);
      tbl[19] = mk(0, 4'b0000, 64'h0, 64'h0, 1, 2, 32'h18, 2'b11, 32'h10);
      tbl[20] = mk(0, 4'b0000, 64'h0, 64'h0, 0, 4, 32'h20, 2'b11, 32'h10);
      tbl[21] = mk(0, 4'b0000, 64'h0, 64'h0, 0, 6, 32'h28, 2'b11, 32'h10);
      tbl[22] = mk(0, 4'b0000, 64'h0, 64'h0, 1, 6, 32'h30, 2'b11, 32'h18);
      tbl[23] = mk(1, 4'b0010, 64'h0, {32'h0, 32'h80}, 1, 0, 32'h00, 2'b00, 32'h00);
      tbl[24] = mk(0, 4'b0000, 64'h0, 64'h0, 0, 2, 32'h08, 2'b11, 32'h00);

      reset = 1'b1; pcsrc_d = '0; pc_predict_d = '0; pc_jump_d = '0; deq_ready = 1'b0;
      #1;

      for (int k = 0; k < 25; k++) begin
         cycle(tbl[k].rst, tbl[k].src, tbl[k].pred, tbl[k].jmp, tbl[k].rdy);
         e_ins0 = tbl[k].e_vld[0] ? (32'hA000_0000 | tbl[k].e_pc0) : 32'h0;
         chk($sformatf("vec%0d_fq_count", k), 64'(fq_count), 64'(tbl[k].e_cnt));
         chk($sformatf("vec%0d_imem_addr", k), 64'(imem_addr), 64'(tbl[k].e_addr));
         chk($sformatf("vec%0d_deq_valid", k), 64'(deq_valid), 64'(tbl[k].e_vld));
         chk($sformatf("vec%0d_pc_f0", k), 64'(pc_f[31:0]), 64'(tbl[k].e_pc0));
         chk($sformatf("vec%0d_instr_f0", k), 64'(instr_f[31:0]), 64'(e_ins0));
      end

      // wrap-around: alternate deq_ready; queue pointers cycle past the last entry
      cycle(1, 4'b0000, 64'h0, 64'h0, 0);
      for (int k = 0; k < 20; k++) begin
         cycle(0, 4'b0000, 64'h0, 64'h0, (k % 2) == 0);
         chk($sformatf("wrap%0d_count_le_depth", k), 64'(fq_count <= 4'd8), 64'd1);
         if (deq_valid == 2'b11)
            chk($sformatf("wrap%0d_lane_contig", k), 64'(pc_f[63:32]), 64'(pc_f[31:0] + 32'd4));
      end

      // random traffic
      for (int k = 0; k < 400; k++) begin
         rst_r = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < W; i++) begin
            case ($urandom_range(0, 15))
               0:       src_r[2*i +: 2] = 2'd1;
               1:       src_r[2*i +: 2] = 2'd2;
               2:       src_r[2*i +: 2] = 2'd3;
               default: src_r[2*i +: 2] = 2'd0;
            endcase
         end
         pred_r = {$urandom(), $urandom()};
         jmp_r  = {$urandom(), $urandom()};
         cycle(rst_r, src_r, pred_r, jmp_r, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/fetch_group_queue.md
# fetch_group_queue

Parametrised N-wide fetch stage with an instruction fetch queue, generalising the dual-lane fetch path to `ISSUE_W` lanes. It owns the fetch PC and reads `ISSUE_W` consecutive words per cycle from instruction memory. Fetched words are buffered in a `FQ_DEPTH`-entry circular queue feeding decode under a ready handshake. Per-lane branch and jump redirects from decode flush the queue and steer the PC, with the oldest lane taking priority.

## Interface
- `ISSUE_W`, default 2: lanes per fetch/decode group; must be ≥1.
- `FQ_DEPTH`, default 8: queue entries; must be a power of two and a multiple of `ISSUE_W`, with `FQ_DEPTH` ≥ 2*`ISSUE_W`.
- `RESET_PC`, default 32'h0: PC loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_addr`  out  32  fetch PC; lane i reads `imem_addr`+4i.
- `imem_rdata`  in  32*`ISSUE_W`  combinational read data; lane i is `[32i+31:32i]`.
- `pcsrc_d`  in  2*`ISSUE_W`  per-lane redirect code: 0 none, 1 branch (use `pc_predict_d`), 2 jump (use `pc_jump_d`), 3 treated as 0.
- `pc_predict_d`  in  32*`ISSUE_W`  per-lane branch target.
- `pc_jump_d`  in  32*`ISSUE_W`  per-lane jump target.
- `deq_ready`  in  1  decode accepts the head group this cycle.
- `deq_valid`  out  `ISSUE_W`  bit i set when lane i of the head group is valid.
- `instr_f`  out  32*`ISSUE_W`  head-group instructions.
- `pc_f`  out  32*`ISSUE_W`  PC of each head-group instruction.
- `pc_plus_w_f`  out  32*`ISSUE_W`  per lane: `pc_f` + 4*`ISSUE_W`, mod 2^32.
- `fq_count`  out  clog2(`FQ_DEPTH`+1)  occupied entries.

## Operation
- **State:** `pc` register; queue storage holding {instr, pc} per entry; head and tail pointers of width log2(`FQ_DEPTH`) that wrap modulo `FQ_DEPTH`; `count` register.
- **Redirect:**
  - `redir` is asserted when any lane has `pcsrc_d` equal to 1 or 2.
  - The winning lane is the lowest index with a nonzero (non-3) code.
  - Target is that lane's `pc_predict_d` or `pc_jump_d`, with bits [1:0] forced to 0.
- **Push:** `push` = !`redir` && `count` ≤ `FQ_DEPTH`−`ISSUE_W`. It writes `ISSUE_W` entries at the tail, with lane i = {`imem_rdata` lane i, `pc`+4i}. Tail and `pc` each advance by `ISSUE_W`/4*`ISSUE_W`; address arithmetic is mod 2^32.
- **Pop:**
  - `pop` = !`redir` && `deq_ready` && `count` ≠ 0.
  - `pop` removes min(`count`, `ISSUE_W`) entries and advances head by the same amount.
  - `deq_valid[i]` = (`count` > i). The head group reads entries head+i mod `FQ_DEPTH`; invalid lanes output 0.
- **Redirect priority:** redirect beats push and pop. On `redir`, `count`, head and tail all go to 0 and `pc` takes the target; the current head group is discarded.
- **Simultaneous push and pop:** `count` next = `count` + `ISSUE_W`·push − popped. The push-space test uses `count` before the pop.
- **Full queue:** no push, and `pc` holds.
- **Empty queue:** `deq_valid` is 0 and `deq_ready` is ignored.
- **Reset** (including mid-operation): `pc`=`RESET_PC`, `count`=0, head=tail=0. Outputs then read `deq_valid`=0, `instr_f`=0, `pc_f`=0, `pc_plus_w_f`=0, `fq_count`=0, and `imem_addr`=`RESET_PC`. Reset outranks redirect.

## Timing
- `imem_addr` = `pc` register; it changes only on the clock edge.
- Fetch-to-decode latency is 1 cycle: words pushed at edge N are visible at the head after N if the queue was empty.
- Redirect-to-target latency:
  - Redirect sampled at edge N: `imem_addr` = target after N.
  - First target group visible after N+1.
  - Bubble: `deq_valid` = 0 for exactly 1 cycle.
- **Throughput:** with `deq_ready` held at 1, one full group of `ISSUE_W` lanes per cycle in steady state, and `fq_count` stays at `ISSUE_W`.
- All outputs are derived from registers only; there is no combinational path from `pcsrc_d` or `deq_ready` to any output.

## Test plan
All scenarios use `ISSUE_W`=2, `FQ_DEPTH`=8, `RESET_PC`=0, and a memory model that returns 32'hA000_0000|addr.

1. **Fill to full:** reset, then `deq_ready`=0 for 5 cycles.
   - `fq_count` goes 0→2→4→6→8, then holds at 8.
   - `imem_addr` stops at 32'h20.
   - Head group is A000_0000/A000_0004 with `pc_f` 0/4 and `pc_plus_w_f` 8/12.
2. **Streaming:** `deq_ready`=1 from reset.
   - Successive head groups have `pc_f` 0/4, 8/12, 16/20.
   - `fq_count` stays at 2, and `deq_valid`=2'b11 every cycle after the first.
3. **Jump on lane 1:** `pcsrc_d`={2,0} with `pc_jump_d` lane 1 = 32'h43.
   - Next cycle: `fq_count`=0, `deq_valid`=0, `imem_addr`=32'h40.
   - Cycle after: `instr_f` = A000_0040/A000_0044.
4. **Both lanes redirect:** lane 0 code 1 with predict 32'h100, lane 1 code 2 with jump 32'h200. Lane 0 wins: `imem_addr`=32'h100. Also check that `pcsrc_d`=3 on all lanes causes no flush.
5. **Reset mid-stream:** assert `reset` with `fq_count`=6 and `pc`=32'h30.
   - Next cycle: `fq_count`=0, `imem_addr`=0, `deq_valid`=0.
   - A concurrent redirect is ignored.
6. **Wrap-around:** toggle `deq_ready` 1,0,1,0 for 20 cycles.
   - Head/tail wrap past entry 7; `pc_f` stays contiguous (+4 per lane).
   - `fq_count` never exceeds 8.
